// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg: shared FSM encoding, default parameters and burst sizing helper
package disp_sched_pkg;

    localparam int DEF_LINE_PIX   = 800;
    localparam int DEF_V_LINES    = 480;
    localparam int DEF_BURST_LEN  = 64;
    localparam int DEF_FIFO_DEPTH = 512;
    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_BASE0      = 0;
    localparam int DEF_BASE1      = 'h100000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_BUSY  = 3'd4;

    function automatic int burst_words(int remain, int burst);
        return (remain < burst) ? remain : burst;
    endfunction

endpackage

// File: rtl/disp_buf_swap.sv
// disp_buf_swap: latches a writer swap request and flips the displayed buffer at the next frame start.
module disp_buf_swap (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_start_i,
    input  logic swap_req_i,
    output logic buf_sel_o
);

    logic swap_pend_q, swap_pend_d;
    logic buf_sel_q, buf_sel_d;
    logic take;

    // a request arriving with the frame start is honoured at that same frame
    assign take = frame_start_i && (swap_pend_q || swap_req_i);

    always_comb begin
        buf_sel_d   = take ? ~buf_sel_q : buf_sel_q;
        swap_pend_d = take ? 1'b0 : (swap_pend_q || swap_req_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            swap_pend_q <= 1'b0;
            buf_sel_q   <= 1'b0;
        end else begin
            swap_pend_q <= swap_pend_d;
            buf_sel_q   <= buf_sel_d;
        end
    end

    assign buf_sel_o = buf_sel_q;

endmodule

// File: rtl/disp_rd_sched.sv
// disp_rd_sched: fetches one display frame per FrameStart as single-outstanding read bursts,
// pacing requests by free space in the display FIFO.
module disp_rd_sched
    import disp_sched_pkg::*;
#(
    parameter int LINE_PIX   = DEF_LINE_PIX,
    parameter int V_LINES    = DEF_V_LINES,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE0 = ADDR_W'(DEF_BASE0),
    parameter logic [ADDR_W-1:0] BASE1 = ADDR_W'(DEF_BASE1)
) (
    input  logic              ClkDisp,
    input  logic              Rst,
    input  logic              FrameStart,
    input  logic [9:0]        FifoUsedw,
    input  logic              BufSwapReq,
    output logic              RdReq,
    output logic [ADDR_W-1:0] RdAddr,
    output logic [7:0]        RdLen,
    input  logic              RdAck,
    input  logic              RdDone,
    output logic              FifoClr,
    output logic              BufSel,
    output logic              Overrun
);

    localparam int          FRAME_WORDS = LINE_PIX * V_LINES;
    localparam int          REM_W       = $clog2(FRAME_WORDS) + 1;
    localparam logic [10:0] BURST_11    = 11'(BURST_LEN);
    localparam logic [10:0] DEPTH_11    = 11'(FIFO_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  remain_q, remain_d;
    logic              pend_q, pend_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        rd_len_q, rd_len_d;
    logic              fifo_clr_q, fifo_clr_d;
    logic              overrun_q, overrun_d;
    logic              space_ok;

    disp_buf_swap u_swap (
        .clk_i         (ClkDisp),
        .rst_i         (Rst),
        .frame_start_i (FrameStart),
        .swap_req_i    (BufSwapReq),
        .buf_sel_o     (BufSel)
    );

    assign space_ok = ({1'b0, FifoUsedw} + BURST_11) <= DEPTH_11;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        pend_d    = pend_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;
        overrun_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = FrameStart ? S_CLEAR : S_IDLE;
            S_CLEAR: begin
                addr_d   = BufSel ? BASE1 : BASE0;
                remain_d = REM_W'(FRAME_WORDS);
                pend_d   = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // a frame start after the last burst completed is not an overrun
                if (remain_q == '0) begin
                    state_d = FrameStart ? S_CLEAR : S_IDLE;
                end else if (FrameStart) begin
                    overrun_d = 1'b1;
                    state_d   = S_CLEAR;
                end else if (space_ok) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_q;
                    rd_len_d  = 8'(burst_words(int'(remain_q), BURST_LEN));
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (FrameStart) begin
                    overrun_d = 1'b1;
                    rd_req_d  = 1'b0;
                    pend_d    = RdAck;
                    state_d   = RdAck ? S_BUSY : S_CLEAR;
                end else if (RdAck) begin
                    rd_req_d = 1'b0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (FrameStart) begin
                    overrun_d = 1'b1;
                    pend_d    = 1'b1;
                end
                if (RdDone) begin
                    addr_d   = addr_q + ADDR_W'(rd_len_q);
                    remain_d = remain_q - REM_W'(rd_len_q);
                    state_d  = (pend_q || FrameStart) ? S_CLEAR : S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        fifo_clr_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge ClkDisp or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE0;
            remain_q   <= '0;
            pend_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= BASE0;
            rd_len_q   <= '0;
            fifo_clr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            pend_q     <= pend_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            fifo_clr_q <= fifo_clr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign RdReq   = rd_req_q;
    assign RdAddr  = rd_addr_q;
    assign RdLen   = rd_len_q;
    assign FifoClr = fifo_clr_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_disp_rd_sched.sv
// tb_disp_rd_sched: directed checks of frame fetch, FIFO pacing, swap, overrun and reset behaviour.
module tb_disp_rd_sched;
    import disp_sched_pkg::*;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  l;
    } burst_t;

    logic        ClkDisp = 1'b0;
    logic        Rst, FrameStart, BufSwapReq, RdAck, RdDone;
    logic [9:0]  FifoUsedw;
    logic        RdReq, FifoClr, BufSel, Overrun;
    logic [23:0] RdAddr;
    logic [7:0]  RdLen;

    int     checks = 0, errors = 0;
    int     ack_dly = 1;
    int     cyc = 0, clr_cnt = 0, ovr_cnt = 0, clr_cyc = 0, done_cyc = 0;
    burst_t bq[$];

    disp_rd_sched #(
        .LINE_PIX(16), .V_LINES(4), .BURST_LEN(24), .FIFO_DEPTH(512)
    ) dut (
        .ClkDisp(ClkDisp), .Rst(Rst), .FrameStart(FrameStart), .FifoUsedw(FifoUsedw),
        .BufSwapReq(BufSwapReq), .RdReq(RdReq), .RdAddr(RdAddr), .RdLen(RdLen),
        .RdAck(RdAck), .RdDone(RdDone), .FifoClr(FifoClr), .BufSel(BufSel), .Overrun(Overrun)
    );

    always #5 ClkDisp = ~ClkDisp;

    always @(posedge ClkDisp) cyc <= cyc + 1;

    always @(negedge ClkDisp) begin
        if (!Rst && RdReq && RdAck) bq.push_back('{RdAddr, RdLen});
        if (FifoClr) begin clr_cnt++; clr_cyc = cyc; end
        if (Overrun) ovr_cnt++;
        if (RdDone) done_cyc = cyc;
    end

    // memory controller: ack ack_dly cycles after the request shows, done 24 cycles after ack
    initial begin
        int wcnt = 0;
        int dcnt = 0;
        RdAck = 1'b0;
        RdDone = 1'b0;
        forever begin
            @(posedge ClkDisp); #1;
            RdAck = 1'b0;
            RdDone = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) RdDone = 1'b1;
            end else if (RdReq) begin
                wcnt++;
                if (wcnt > ack_dly) begin RdAck = 1'b1; wcnt = 0; dcnt = 24; end
            end else wcnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ClkDisp); #1;
    endtask

    task automatic pulse_fs(input logic sw);
        FrameStart = 1'b1;
        BufSwapReq = sw;
        tick();
        FrameStart = 1'b0;
        BufSwapReq = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dut.state_q != S_IDLE && n < 400) begin tick(); n++; end
        chk(tag, 32'(dut.state_q), 32'(S_IDLE));
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!RdReq && n < 50) begin tick(); n++; end
        chk(tag, 32'(RdReq), 1);
    endtask

    task automatic chk_burst(input string tag, input int i, input logic [23:0] a, input logic [7:0] l);
        chk({tag, "_addr"}, 32'(bq[i].a), 32'(a));
        chk({tag, "_len"}, 32'(bq[i].l), 32'(l));
    endtask

    initial begin
        int c0, o0;
        logic seen;
        Rst = 1'b1; FrameStart = 1'b0; BufSwapReq = 1'b0; FifoUsedw = '0;
        tick(); tick();
        @(negedge ClkDisp);
        chk("rst_req", 32'(RdReq), 0);
        chk("rst_addr", 32'(RdAddr), 0);
        chk("rst_len", 32'(RdLen), 0);
        chk("rst_clr", 32'(FifoClr), 0);
        chk("rst_bufsel", 32'(BufSel), 0);
        chk("rst_ovr", 32'(Overrun), 0);
        tick();
        Rst = 1'b0;
        tick(); tick();

        // single frame: clear pulse, three bursts, back to idle
        bq.delete();
        c0 = clr_cnt;
        pulse_fs(1'b0);
        @(negedge ClkDisp);
        chk("f1_clr", 32'(FifoClr), 1);
        chk("f1_req_n1", 32'(RdReq), 0);
        @(negedge ClkDisp);
        chk("f1_clr_off", 32'(FifoClr), 0);
        chk("f1_req_n2", 32'(RdReq), 0);
        @(negedge ClkDisp);
        chk("f1_req_n3", 32'(RdReq), 1);
        wait_idle("f1_idle");
        chk("f1_nb", 32'(bq.size()), 3);
        chk_burst("f1_b0", 0, 24'd0, 8'd24);
        chk_burst("f1_b1", 1, 24'd24, 8'd24);
        chk_burst("f1_b2", 2, 24'd48, 8'd16);
        chk("f1_nclr", 32'(clr_cnt - c0), 1);
        chk("f1_novr", 32'(ovr_cnt), 0);

        // FIFO space pacing at the 512-word boundary
        FifoUsedw = 10'd500;
        pulse_fs(1'b0);
        seen = 1'b0;
        repeat (15) begin tick(); seen |= RdReq; end
        chk("full500_noreq", 32'(seen), 0);
        FifoUsedw = 10'd489;
        repeat (5) begin tick(); seen |= RdReq; end
        chk("full489_noreq", 32'(seen), 0);
        FifoUsedw = 10'd488;
        repeat (2) begin tick(); seen |= RdReq; end
        chk("space488_req", 32'(seen), 1);
        chk("space488_addr", 32'(RdAddr), 0);
        wait_idle("sp_idle");
        FifoUsedw = '0;

        // request held without ack
        ack_dly = 10;
        pulse_fs(1'b0);
        wait_req("hold_req");
        repeat (10) begin
            @(negedge ClkDisp);
            chk("hold_req_hi", 32'(RdReq), 1);
            chk("hold_addr", 32'(RdAddr), 0);
            chk("hold_len", 32'(RdLen), 24);
        end
        ack_dly = 1;
        tick();
        wait_idle("hold_idle");

        // buffer swap, requested ahead of and coincident with frame start
        BufSwapReq = 1'b1;
        tick();
        BufSwapReq = 1'b0;
        tick(); tick();
        chk("swap_wait_bufsel", 32'(BufSel), 0);
        bq.delete();
        pulse_fs(1'b0);
        @(negedge ClkDisp);
        chk("swap_bufsel", 32'(BufSel), 1);
        wait_idle("swap_idle");
        chk("swap_nb", 32'(bq.size()), 3);
        chk_burst("swap_b0", 0, 24'h100000, 8'd24);
        chk_burst("swap_b2", 2, 24'h100030, 8'd16);
        bq.delete();
        pulse_fs(1'b1);
        @(negedge ClkDisp);
        chk("coin_bufsel", 32'(BufSel), 0);
        wait_idle("coin_idle");
        chk_burst("coin_b0", 0, 24'd0, 8'd24);

        // frame start while the second burst is in flight
        bq.delete();
        c0 = clr_cnt;
        o0 = ovr_cnt;
        pulse_fs(1'b0);
        begin
            int n = 0;
            while (bq.size() < 2 && n < 200) begin tick(); n++; end
        end
        chk("ovr_b1_seen", 32'(bq.size()), 2);
        repeat (5) tick();
        pulse_fs(1'b0);
        @(negedge ClkDisp);
        chk("ovr_pulse", 32'(Overrun), 1);
        chk("ovr_no_clr", 32'(FifoClr), 0);
        @(negedge ClkDisp);
        chk("ovr_pulse_end", 32'(Overrun), 0);
        begin
            int n = 0;
            while (clr_cnt - c0 < 2 && n < 60) begin tick(); n++; end
        end
        chk("ovr_clr_after_done", 32'(clr_cyc - done_cyc), 1);
        wait_idle("ovr_idle");
        chk("ovr_nb", 32'(bq.size()), 5);
        chk_burst("ovr_b2", 2, 24'd0, 8'd24);
        chk_burst("ovr_b4", 4, 24'd48, 8'd16);
        chk("ovr_cnt", 32'(ovr_cnt - o0), 1);

        // reset while a request is waiting for ack
        bq.delete();
        ack_dly = 10;
        pulse_fs(1'b1);
        wait_req("rq_req");
        chk("rq_addr", 32'(RdAddr), 32'h100000);
        tick(); tick();
        Rst = 1'b1;
        #1;
        chk("rq_rst_req", 32'(RdReq), 0);
        chk("rq_rst_addr", 32'(RdAddr), 0);
        chk("rq_rst_len", 32'(RdLen), 0);
        chk("rq_rst_clr", 32'(FifoClr), 0);
        chk("rq_rst_bufsel", 32'(BufSel), 0);
        chk("rq_rst_ovr", 32'(Overrun), 0);
        tick();
        Rst = 1'b0;
        ack_dly = 1;
        c0 = clr_cnt;
        repeat (5) tick();
        chk("rq_noclr", 32'(clr_cnt - c0), 0);
        chk("rq_idle", 32'(dut.state_q), 32'(S_IDLE));
        pulse_fs(1'b0);
        wait_idle("post_idle");
        chk("post_nb", 32'(bq.size()), 3);
        chk_burst("post_b0", 0, 24'd0, 8'd24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
